// File: rtl/bz_play_arbiter.sv
// rtl/bz_play_arbiter.sv - fixed-priority arbiter sharing one buzzer music player
// Outputs are registered from next-state values, so every pulse appears one edge after its decision.
module bz_play_arbiter #(
   parameter int NREQ       = 4,
   parameter int SONG_W     = 5,
   parameter int GAP_CYCLES = 1000,
   parameter int GAP_W      = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*SONG_W-1:0] req_song,
   output logic [NREQ-1:0]        grant,
   output logic [NREQ-1:0]        done,
   output logic                   busy,
   output logic                   play_start,
   output logic                   play_abort,
   output logic [SONG_W-1:0]      play_song,
   input  logic                   play_done
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_PLAY, S_GAP} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [SONG_W-1:0]  song_q, song_d;
   logic [GAP_W-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0]    grant_q, grant_d;
   logic [NREQ-1:0]    done_q, done_d;
   logic               busy_q, busy_d;
   logic               start_q, start_d;
   logic               abort_q, abort_d;

   logic               sel_vld;
   logic [IDX_W-1:0]   sel_idx;
   logic               preempt;
   logic               cancel;

   // Lowest set index wins; scanning downward leaves the smallest one.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            sel_vld = 1'b1;
            sel_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      preempt = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (req[i] && (i < int'(idx_q))) preempt = 1'b1;
      end
      cancel = !req[idx_q];
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      song_d  = song_q;
      cnt_d   = cnt_q;
      done_d  = '0;
      start_d = 1'b0;
      abort_d = 1'b0;
      grant_d = '0;
      case (state_q)
         S_IDLE: begin
            if (sel_vld) begin
               idx_d   = sel_idx;
               song_d  = req_song[sel_idx*SONG_W +: SONG_W];
               state_d = S_START;
            end
         end
         S_START: begin
            start_d = 1'b1;
            state_d = S_PLAY;
         end
         S_PLAY: begin
            // Completion outranks a same-cycle cancel or preempt.
            if (play_done) begin
               done_d[idx_q] = 1'b1;
               cnt_d         = GAP_LOAD;
               state_d       = S_GAP;
            end else if (cancel || preempt) begin
               abort_d = 1'b1;
               cnt_d   = GAP_LOAD;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_PLAY) grant_d[idx_d] = 1'b1;
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         song_q  <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         song_q  <= song_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         start_q <= start_d;
         abort_q <= abort_d;
      end
   end

   assign grant      = grant_q;
   assign done       = done_q;
   assign busy       = busy_q;
   assign play_start = start_q;
   assign play_abort = abort_q;
   assign play_song  = song_q;

endmodule

// File: tb/tb_bz_play_arbiter.sv
// tb/tb_bz_play_arbiter.sv - scoreboard bench for bz_play_arbiter
// Expected start/done/abort events are queued by the stimulus and matched by a negedge monitor.
module tb_bz_play_arbiter;

   localparam int NREQ = 4;
   localparam int SW   = 5;
   localparam int G    = 8;
   localparam int GW   = 4;

   localparam logic [1:0] EV_START = 2'd1;
   localparam logic [1:0] EV_DONE  = 2'd2;
   localparam logic [1:0] EV_ABORT = 2'd3;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*SW-1:0] req_song = '0;
   logic              play_done = 1'b0;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   done;
   logic              busy;
   logic              play_start;
   logic              play_abort;
   logic [SW-1:0]     play_song;

   int                n_checks = 0;
   int                n_fail = 0;
   logic [8:0]        sb_q[$];
   logic [1:0]        last_idx = '0;
   int                c;

   bz_play_arbiter #(.NREQ(NREQ), .SONG_W(SW), .GAP_CYCLES(G), .GAP_W(GW)) dut (
      .clk(clk), .rstn(rstn), .req(req), .req_song(req_song),
      .grant(grant), .done(done), .busy(busy),
      .play_start(play_start), .play_abort(play_abort),
      .play_song(play_song), .play_done(play_done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] ev(input logic [1:0] t, input logic [1:0] i, input logic [4:0] s);
      return {t, i, s};
   endfunction

   function automatic logic [1:0] enc(input logic [3:0] v);
      logic [1:0] r = '0;
      for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
      return r;
   endfunction

   task automatic sb_pop(input logic [8:0] obs);
      if (sb_q.size() == 0) check_eq("sb_unexpected", 32'(obs), 32'h0);
      else                  check_eq("sb_event", 32'(obs), 32'(sb_q.pop_front()));
   endtask

   task automatic push_ev(input logic [1:0] t, input logic [1:0] i, input logic [4:0] s);
      sb_q.push_back(ev(t, i, s));
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [4:0] s);
      req[i] = v;
      req_song[i*SW +: SW] = s;
   endtask

   task automatic wait_start(input int bound, output int cyc);
      cyc = 0;
      do begin
         tick(1);
         cyc++;
      end while (!play_start && cyc < bound);
   endtask

   task automatic wait_idle(input int bound, output int cyc);
      cyc = 0;
      do begin
         tick(1);
         cyc++;
      end while (busy && cyc < bound);
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         if (play_start) begin
            check_eq("grant_onehot", 32'($countones(grant)), 32'd1);
            last_idx = enc(grant);
            sb_pop(ev(EV_START, enc(grant), play_song));
         end
         if (|done) begin
            check_eq("done_onehot", 32'($countones(done)), 32'd1);
            sb_pop(ev(EV_DONE, enc(done), play_song));
         end
         if (play_abort) sb_pop(ev(EV_ABORT, last_idx, play_song));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(2);
      check_eq("rst_grant", 32'(grant), 32'h0);
      check_eq("rst_done", 32'(done), 32'h0);
      check_eq("rst_busy", 32'(busy), 32'h0);
      check_eq("rst_start", 32'(play_start), 32'h0);
      check_eq("rst_abort", 32'(play_abort), 32'h0);
      check_eq("rst_song", 32'(play_song), 32'h0);
      rstn = 1'b1;
      tick(2);
      check_eq("idle_busy", 32'(busy), 32'h0);

      // single request, song completes
      set_req(3, 1'b1, 5'd7);
      push_ev(EV_START, 2'd3, 5'd7);
      wait_start(10, c);
      check_eq("t1_latency", 32'(c), 32'd2);
      check_eq("t1_song", 32'(play_song), 32'd7);
      check_eq("t1_grant", 32'(grant), 32'b1000);
      check_eq("t1_busy", 32'(busy), 32'h1);
      tick(19);
      check_eq("t1_grant_hold", 32'(grant), 32'b1000);
      play_done = 1'b1;
      push_ev(EV_DONE, 2'd3, 5'd7);
      tick(1);
      play_done = 1'b0;
      set_req(3, 1'b0, 5'd7);
      check_eq("t1_grant_clr", 32'(grant), 32'h0);
      wait_idle(G + 5, c);
      check_eq("t1_busy_clear", 32'(c), 32'(G));

      // preemption, then restart of the preempted song
      set_req(3, 1'b1, 5'd2);
      push_ev(EV_START, 2'd3, 5'd2);
      wait_start(10, c);
      tick(5);
      set_req(1, 1'b1, 5'd9);
      push_ev(EV_ABORT, 2'd3, 5'd2);
      push_ev(EV_START, 2'd1, 5'd9);
      tick(1);
      check_eq("t2_abort", 32'(play_abort), 32'h1);
      check_eq("t2_grant_clr", 32'(grant), 32'h0);
      check_eq("t2_no_done", 32'(done), 32'h0);
      wait_start(G + 10, c);
      check_eq("t2_restart_lat", 32'(c), 32'(G + 2));
      check_eq("t2_grant", 32'(grant), 32'b0010);
      check_eq("t2_song", 32'(play_song), 32'd9);
      tick(10);
      play_done = 1'b1;
      push_ev(EV_DONE, 2'd1, 5'd9);
      tick(1);
      play_done = 1'b0;
      set_req(1, 1'b0, 5'd9);
      push_ev(EV_START, 2'd3, 5'd2);
      wait_start(G + 10, c);
      check_eq("t2_regrant_lat", 32'(c), 32'(G + 2));
      check_eq("t2_regrant", 32'(grant), 32'b1000);
      check_eq("t2_regrant_song", 32'(play_song), 32'd2);

      // cancel mid-song
      tick(4);
      set_req(3, 1'b0, 5'd2);
      push_ev(EV_ABORT, 2'd3, 5'd2);
      tick(1);
      check_eq("t4_abort", 32'(play_abort), 32'h1);
      check_eq("t4_no_done", 32'(done), 32'h0);
      wait_idle(G + 5, c);
      check_eq("t4_busy_clear", 32'(c), 32'(G));

      // simultaneous requests
      set_req(1, 1'b1, 5'd3);
      set_req(2, 1'b1, 5'd4);
      push_ev(EV_START, 2'd1, 5'd3);
      wait_start(10, c);
      check_eq("t3_grant1", 32'(grant), 32'b0010);
      tick(6);
      play_done = 1'b1;
      push_ev(EV_DONE, 2'd1, 5'd3);
      tick(1);
      play_done = 1'b0;
      set_req(1, 1'b0, 5'd3);
      push_ev(EV_START, 2'd2, 5'd4);
      wait_start(G + 10, c);
      check_eq("t3_grant2", 32'(grant), 32'b0100);
      check_eq("t3_song2", 32'(play_song), 32'd4);

      // play_done collides with higher-priority request
      tick(5);
      play_done = 1'b1;
      set_req(0, 1'b1, 5'd11);
      push_ev(EV_DONE, 2'd2, 5'd4);
      push_ev(EV_START, 2'd0, 5'd11);
      tick(1);
      play_done = 1'b0;
      set_req(2, 1'b0, 5'd4);
      check_eq("t5_no_abort", 32'(play_abort), 32'h0);
      check_eq("t5_done", 32'(done), 32'b0100);
      wait_start(G + 10, c);
      check_eq("t5_grant", 32'(grant), 32'b0001);
      check_eq("t5_song", 32'(play_song), 32'd11);
      tick(3);
      play_done = 1'b1;
      push_ev(EV_DONE, 2'd0, 5'd11);
      tick(1);
      play_done = 1'b0;
      set_req(0, 1'b0, 5'd11);
      wait_idle(G + 5, c);

      // asynchronous reset mid-PLAY
      set_req(2, 1'b1, 5'd6);
      push_ev(EV_START, 2'd2, 5'd6);
      wait_start(10, c);
      tick(3);
      #2;
      rstn = 1'b0;
      #1;
      check_eq("t6_grant", 32'(grant), 32'h0);
      check_eq("t6_busy", 32'(busy), 32'h0);
      check_eq("t6_song", 32'(play_song), 32'h0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      push_ev(EV_START, 2'd2, 5'd6);
      wait_start(10, c);
      check_eq("t6_latency", 32'(c), 32'd2);
      set_req(2, 1'b0, 5'd6);
      push_ev(EV_ABORT, 2'd2, 5'd6);
      tick(1);
      wait_idle(G + 5, c);
      check_eq("t6_idle", 32'(busy), 32'h0);

      tick(3);
      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bz_play_arbiter.md
Name: bz_play_arbiter

Overview:
Shares the single buzzer music player (sequencer + address counter + song ROM + tune/beat generators) between NREQ requesters, e.g. background music from the CPU register and game sound effects. Fixed-priority arbitration; a higher-priority request preempts a lower-priority one. Each song is a start/abort handshake to the player, followed by a silence gap. Sits between the SoC/game logic and the player's start/mode inputs.

Parameters:
NREQ, 4, number of requesters; index 0 is highest priority.
SONG_W, 5, song-select width passed to the player.
GAP_CYCLES, 1000, silence cycles after every stop or abort; must be >= 1.
GAP_W, 16, gap counter width; must satisfy GAP_CYCLES < 2^GAP_W.

Ports:
clk  in  1  system clock.
rstn  in  1  reset; asynchronous, active-low.
req  in  NREQ  per-requester level request; held until done or cancel.
req_song  in  NREQ*SONG_W  packed song ids; requester i uses bits [i*SONG_W +: SONG_W].
grant  out  NREQ  one-hot; the requester currently owning the player.
done  out  NREQ  one-cycle pulse to requester i on normal song completion.
busy  out  1  high whenever the FSM is not in IDLE.
play_start  out  1  one-cycle pulse; the player starts song play_song.
play_abort  out  1  one-cycle pulse; the player stops immediately and silences.
play_song  out  SONG_W  latched song id; stable from START until the next grant.
play_done  in  1  one-cycle pulse from the player at end of song.

Behaviour:
- Reset (async, any state): FSM to IDLE. Outputs grant=0, done=0, busy=0, play_start=0, play_abort=0, play_song=0. Gap counter cleared.
- States: IDLE, START, PLAY, GAP.
- IDLE:
  - If any req bit is set, select the lowest set index k.
  - Latch k and req_song[k] into play_song.
  - Go to START next cycle. Latency from req rising to play_start is 2 cycles.
- START:
  - play_start=1 for exactly this cycle.
  - grant[k]=1 from this cycle until leaving PLAY.
  - Go to PLAY.
- PLAY, with priority order:
  1. play_done=1: done[k]=1 for one cycle, grant cleared, go to GAP. This holds even if a preempt or cancel condition is present in the same cycle; completion wins.
  2. req[k]=0 (cancel), or any req[j]=1 with j<k (preempt): play_abort=1 for one cycle, grant cleared, no done pulse, go to GAP.
  3. Otherwise stay in PLAY. Changes to req_song[k] during PLAY are ignored.
- GAP:
  - Counter loads GAP_CYCLES-1 on entry and decrements each cycle.
  - At 0, go to IDLE.
  - play_start, play_abort and grant are all 0 throughout.
  - play_done pulses arriving in GAP are ignored.
- A preempted requester that still holds req is re-arbitrated normally and its song restarts from the beginning. There is no resume.
- A requester must drop req within GAP_CYCLES after its done pulse. If it does not, it is re-granted and its song replays.
- A req pulse shorter than the IDLE sampling cycle may be missed. Requesters hold req as a level.
- Outputs are registered. grant and busy are decoded from registered state/index and carry no combinational path from req.
- busy=1 in START, PLAY and GAP.

Test Plan:
1. Single request: req=4'b1000, song 5'd7; player pulses play_done 20 cycles after start -> play_start 2 cycles after req; play_song=7; grant=4'b1000 until play_done; done[3] pulses once; busy clears GAP_CYCLES cycles after play_done.
2. Preemption: req[3] playing song 2, then req[1] rises with song 9 -> next cycle play_abort=1 and grant=0, no done[3]; after GAP_CYCLES, play_start with play_song=9 and grant=4'b0010. After done[1] and req[1] drop, req[3] is re-granted and song 2 restarts.
3. Simultaneous requests: req=4'b0110 asserted in the same cycle -> requester 1 granted first. After its done and req[1] drop, requester 2 is granted.
4. Cancel: drop req[k] mid-song -> play_abort pulse the next cycle, no done, GAP entered; with no other requests, the FSM returns to IDLE and busy=0.
5. Collision: play_done coincides with a higher-priority req rise -> done[k] pulses and play_abort stays 0; the higher-priority requester is granted after the gap.
6. Reset mid-PLAY: assert rstn=0 asynchronously -> all outputs are 0 immediately without waiting for a clock edge. After release with req held, a fresh play_start occurs 2 cycles later.
